// File: rtl/dds_multi_sweep.sv
// Multi-channel DDS with one shared phase accumulator, a loadable sine LUT, a linear chirp engine,
// per-channel phase offset and amplitude, and a saturating 3-stage output pipeline.
module dds_multi_sweep #(
    parameter int NUM_CH = 2,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int AMP_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [ACC_W-1:0]         freq_word,
    input  logic [ACC_W-1:0]         sweep_step,
    input  logic [31:0]              sweep_len,
    input  logic                     sweep_start,
    input  logic [NUM_CH*ACC_W-1:0]  phase_ofs,
    input  logic [NUM_CH*AMP_W-1:0]  ampl,
    input  logic [DATA_W-1:0]        direct_value,
    input  logic                     lut_we,
    input  logic [ADDR_W-1:0]        lut_addr,
    input  logic [DATA_W-1:0]        lut_data,
    output logic [NUM_CH*DATA_W-1:0] sample_out,
    output logic                     sample_valid,
    output logic                     sweep_busy,
    output logic                     sweep_done
);
    localparam int PROD_W = DATA_W + AMP_W;
    localparam logic [1:0] MODE_SWEEP  = 2'd1;
    localparam logic [1:0] MODE_DIRECT = 2'd2;
    localparam logic [1:0] MODE_PRST   = 2'd3;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} sweep_state_t;

    sweep_state_t state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] freq_cur;
    logic [31:0]      cnt;
    logic             sw_load;
    logic             sw_step;

    logic signed [DATA_W-1:0] lut_mem [2**ADDR_W];
    logic [ADDR_W-1:0]        rd_addr [NUM_CH];
    logic signed [DATA_W-1:0] lut_p0  [NUM_CH];
    logic [1:0]               mode_p0;
    logic signed [DATA_W-1:0] dval_p0;
    logic signed [PROD_W-1:0] prod_p1 [NUM_CH];
    logic                     vld_p0;
    logic                     vld_p1;

    // Undo the Q(AMP_W-1) amplitude scaling and clamp into the DATA_W signed range.
    function automatic logic [DATA_W-1:0] sat_shift(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W-1:0] s;
        s = p >>> (AMP_W - 1);
        if (!s[PROD_W-1] && (|s[PROD_W-2:DATA_W-1]))
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (s[PROD_W-1] && !(&s[PROD_W-2:DATA_W-1]))
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return s[DATA_W-1:0];
    endfunction

    // Pre-scale a direct value so the common shift/saturate stage returns it unchanged.
    function automatic logic signed [PROD_W-1:0] align_direct(input logic signed [DATA_W-1:0] d);
        return PROD_W'(d) <<< (AMP_W - 1);
    endfunction

    always_comb begin
        state_nxt  = state;
        sweep_busy = 1'b0;
        sweep_done = 1'b0;
        sw_load    = 1'b0;
        sw_step    = 1'b0;
        case (state)
            IDLE: begin
                if (mode == MODE_SWEEP && sweep_start) begin
                    sw_load   = 1'b1;
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                sweep_busy = 1'b1;
                if (mode != MODE_SWEEP) begin
                    state_nxt = IDLE;
                end else if (en) begin
                    if (cnt != 32'd0) sw_step = 1'b1;
                    else              state_nxt = DONE;
                end
            end
            DONE: begin
                sweep_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Outside sweep mode the tone word is tracked continuously so a mode change takes effect at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            freq_cur <= '0;
            cnt      <= '0;
        end else begin
            if (en) acc <= (mode == MODE_PRST) ? '0 : acc + freq_cur;
            if (mode != MODE_SWEEP || sw_load) freq_cur <= freq_word;
            else if (sw_step)                  freq_cur <= freq_cur + sweep_step;
            if (sw_load)      cnt <= sweep_len;
            else if (sw_step) cnt <= cnt - 32'd1;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++)
            rd_addr[c] = ADDR_W'((acc + phase_ofs[c*ACC_W +: ACC_W]) >> (ACC_W - ADDR_W));
    end

    always_ff @(posedge clk) begin
        if (lut_we) lut_mem[lut_addr] <= lut_data;
    end

    // Stage p0: LUT read per channel plus the mode/direct value that travel with it
    always_ff @(posedge clk) begin
        if (en) begin
            for (int c = 0; c < NUM_CH; c++) lut_p0[c] <= lut_mem[rd_addr[c]];
            mode_p0 <= mode;
            dval_p0 <= direct_value;
        end
    end

    // Stage p1: amplitude product
    always_ff @(posedge clk) begin
        if (en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                case (mode_p0)
                    MODE_DIRECT: prod_p1[c] <= align_direct(dval_p0);
                    MODE_PRST:   prod_p1[c] <= '0;
                    default:     prod_p1[c] <= PROD_W'(lut_p0[c]) * PROD_W'($signed(ampl[c*AMP_W +: AMP_W]));
                endcase
            end
        end
    end

    // Stage p2: shift, saturate and register to the output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            sample_valid <= 1'b0;
            sample_out   <= '0;
        end else if (en) begin
            vld_p0       <= 1'b1;
            vld_p1       <= vld_p0;
            sample_valid <= vld_p1;
            for (int c = 0; c < NUM_CH; c++)
                sample_out[c*DATA_W +: DATA_W] <= sat_shift(prod_p1[c]);
        end else begin
            sample_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dds_multi_sweep.sv
// Directed bench for dds_multi_sweep: a spec-level reference model checked every cycle,
// plus hand-computed literal expectations for ramp, saturation, sweep, abort, modes and reset.
module tb_dds_multi_sweep;
    localparam int NUM_CH = 2;
    localparam int ACC_W  = 32;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int AMP_W  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en;
    logic [1:0]  mode;
    logic [31:0] freq_word, sweep_step, sweep_len;
    logic        sweep_start;
    logic [63:0] phase_ofs;
    logic [31:0] ampl;
    logic [15:0] direct_value;
    logic        lut_we;
    logic [7:0]  lut_addr;
    logic [15:0] lut_data;
    logic [31:0] sample_out;
    logic        sample_valid, sweep_busy, sweep_done;

    always #5 clk = ~clk;

    dds_multi_sweep #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AMP_W(AMP_W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .freq_word(freq_word), .sweep_step(sweep_step),
        .sweep_len(sweep_len), .sweep_start(sweep_start), .phase_ofs(phase_ofs), .ampl(ampl),
        .direct_value(direct_value), .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
        .sample_out(sample_out), .sample_valid(sample_valid), .sweep_busy(sweep_busy), .sweep_done(sweep_done)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    logic signed [15:0] m_lut [256];
    logic [31:0] m_acc, m_freq, m_left;
    int          m_phase;   // 0 idle, 1 sweeping, 2 done
    logic signed [15:0] m_rd [2];
    logic [1:0]  m_rd_mode;
    logic [15:0] m_rd_dval;
    logic [15:0] m_scaled [2];
    logic [15:0] m_out [2];
    int          m_en_cnt;
    logic        m_valid;

    function automatic logic [15:0] scale(input logic signed [15:0] v, input logic signed [15:0] a);
        longint p;
        p = (longint'(v) * longint'(a)) >>> 15;
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc <= '0; m_freq <= '0; m_left <= '0; m_phase <= 0;
            m_out[0] <= '0; m_out[1] <= '0; m_en_cnt <= 0; m_valid <= 1'b0;
        end else begin
            case (m_phase)
                0: if (mode == 2'd1 && sweep_start) begin m_phase <= 1; m_left <= sweep_len; end
                1: if (mode != 2'd1) m_phase <= 0;
                   else if (en) begin
                       if (m_left != 0) m_left <= m_left - 32'd1;
                       else             m_phase <= 2;
                   end
                default: m_phase <= 0;
            endcase
            if (mode != 2'd1)                              m_freq <= freq_word;
            else if (m_phase == 0 && sweep_start)          m_freq <= freq_word;
            else if (m_phase == 1 && en && m_left != 0)    m_freq <= m_freq + sweep_step;
            if (en) begin
                m_acc <= (mode == 2'd3) ? 32'd0 : m_acc + m_freq;
                for (int c = 0; c < 2; c++) begin
                    m_rd[c]     <= m_lut[8'((m_acc + phase_ofs[c*32 +: 32]) >> 24)];
                    m_scaled[c] <= (m_rd_mode == 2'd2) ? m_rd_dval :
                                   (m_rd_mode == 2'd3) ? 16'd0 : scale(m_rd[c], ampl[c*16 +: 16]);
                    m_out[c]    <= m_scaled[c];
                end
                m_rd_mode <= mode;
                m_rd_dval <= direct_value;
                m_en_cnt  <= m_en_cnt + 1;
                m_valid   <= (m_en_cnt >= 2);
            end else begin
                m_valid <= 1'b0;
            end
            if (lut_we) m_lut[lut_addr] <= lut_data;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("valid", 64'(sample_valid), 64'(m_valid));
            check("busy", 64'(sweep_busy), 64'(m_phase == 1));
            check("done", 64'(sweep_done), 64'(m_phase == 2));
            check("freq_cur", 64'(dut.freq_cur), 64'(m_freq));
            if (m_en_cnt == 0 || m_en_cnt >= 3) begin
                check("ch0", 64'(sample_out[15:0]), 64'(m_out[0]));
                check("ch1", 64'(sample_out[31:16]), 64'(m_out[1]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_sweep(input bit toggle, output int busy, output bit seen);
        busy = 0;
        seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            if (sweep_busy) busy++;
            if (toggle) en = ~en;
            tick();
            seen = sweep_done;
        end
    endtask

    int busy_cnt;
    bit seen, any_done;

    initial begin
        en = 0; mode = 0; freq_word = 0; sweep_step = 0; sweep_len = 0; sweep_start = 0;
        phase_ofs = '0; ampl = '0; direct_value = '0; lut_we = 0; lut_addr = '0; lut_data = '0;
        rst = 1;
        repeat (3) tick();
        check("rst_sample_out", 64'(sample_out), 64'(0));
        check("rst_valid", 64'(sample_valid), 64'(0));
        check("rst_busy", 64'(sweep_busy), 64'(0));
        check("rst_done", 64'(sweep_done), 64'(0));
        check("rst_freq", 64'(dut.freq_cur), 64'(0));
        rst = 0;

        for (int i = 0; i < 256; i++) begin
            lut_we = 1; lut_addr = 8'(i); lut_data = 16'(i * 256);
            tick();
        end
        lut_we = 0;

        // ramp with a LUT write racing the read of address 5
        mode = 0; freq_word = 32'h0100_0000;
        phase_ofs = {32'h8000_0000, 32'h0};
        ampl = {16'h4000, 16'h4000};
        tick();
        en = 1;
        for (int e = 1; e <= 266; e++) begin
            lut_we = (e == 6); lut_addr = 8'd5; lut_data = 16'h7FFF;
            tick();
            lut_we = 0;
            if (e == 2) check("ramp_warmup_valid", 64'(sample_valid), 64'(0));
            if (e == 3) begin
                check("ramp_first_valid", 64'(sample_valid), 64'(1));
                check("ramp_a0_ch0", 64'(sample_out[15:0]), 64'(16'h0000));
                check("ramp_a0_ch1", 64'(sample_out[31:16]), 64'(16'hC000));
            end
            if (e == 4) begin
                check("ramp_a1_ch0", 64'(sample_out[15:0]), 64'(16'h0080));
                check("ramp_a1_ch1", 64'(sample_out[31:16]), 64'(16'hC080));
            end
            if (e == 8)   check("lut_old_data", 64'(sample_out[15:0]), 64'(16'h0280));
            if (e == 136) check("lut_new_ch1", 64'(sample_out[31:16]), 64'(16'h3FFF));
            if (e == 264) check("lut_new_ch0", 64'(sample_out[15:0]), 64'(16'h3FFF));
        end
        lut_we = 1; lut_addr = 8'd5; lut_data = 16'h0500;
        tick();
        lut_we = 0;

        // phase reset for one cycle restarts the ramp at address 0
        mode = 3; tick(); mode = 0;
        tick(); tick();
        check("prst_zero_ch1", 64'(sample_out[31:16]), 64'(0));
        tick();
        check("prst_restart_ch1", 64'(sample_out[31:16]), 64'(16'hC000));
        tick();
        check("prst_restart_ch0", 64'(sample_out[15:0]), 64'(16'h0080));

        // direct value
        direct_value = 16'h1234; mode = 2;
        repeat (3) tick();
        check("direct_ch0", 64'(sample_out[15:0]), 64'(16'h1234));
        check("direct_ch1", 64'(sample_out[31:16]), 64'(16'h1234));
        mode = 0;

        // saturation
        mode = 3; freq_word = 0; ampl = {16'h8000, 16'h8000};
        lut_we = 1; lut_addr = 8'd0; lut_data = 16'h8000;
        tick();
        lut_we = 0; mode = 0;
        repeat (4) tick();
        check("sat_pos_ch0", 64'(sample_out[15:0]), 64'(16'h7FFF));
        check("sat_pos_ch1", 64'(sample_out[31:16]), 64'(16'h7FFF));
        ampl = {16'h7FFF, 16'h7FFF};
        repeat (3) tick();
        check("sat_neg_ch0", 64'(sample_out[15:0]), 64'(16'h8001));
        lut_we = 1; lut_addr = 8'd0; lut_data = 16'h0000;
        tick();
        lut_we = 0;

        // sweep, continuous enable
        mode = 1; freq_word = 32'h0100_0000; sweep_step = 32'h0100_0000; sweep_len = 4;
        sweep_start = 1; tick(); sweep_start = 0;
        run_sweep(1'b0, busy_cnt, seen);
        check("sweep_done_seen", 64'(seen), 64'(1));
        check("sweep_busy_len", 64'(busy_cnt), 64'(5));
        check("sweep_final_freq", 64'(dut.freq_cur), 64'(32'h0500_0000));
        tick();
        check("sweep_done_pulse", 64'(sweep_done), 64'(0));

        // sweep, enable toggled every cycle
        sweep_start = 1; tick(); sweep_start = 0;
        run_sweep(1'b1, busy_cnt, seen);
        en = 1;
        check("sweep_tog_done_seen", 64'(seen), 64'(1));
        check("sweep_tog_busy_len", 64'(busy_cnt), 64'(10));
        check("sweep_tog_final_freq", 64'(dut.freq_cur), 64'(32'h0500_0000));
        tick();

        // zero-length sweep
        freq_word = 32'h0300_0000; sweep_len = 0;
        sweep_start = 1; tick(); sweep_start = 0;
        check("len0_busy", 64'(sweep_busy), 64'(1));
        check("len0_no_done_yet", 64'(sweep_done), 64'(0));
        tick();
        check("len0_done", 64'(sweep_done), 64'(1));
        check("len0_freq", 64'(dut.freq_cur), 64'(32'h0300_0000));
        tick();
        check("len0_idle", 64'(sweep_busy | sweep_done), 64'(0));

        // abort by leaving sweep mode
        freq_word = 32'h0100_0000; sweep_len = 4;
        sweep_start = 1; tick(); sweep_start = 0; tick();
        mode = 0; freq_word = 32'h0A00_0000;
        tick();
        check("abort_busy", 64'(sweep_busy), 64'(0));
        check("abort_freq", 64'(dut.freq_cur), 64'(32'h0A00_0000));
        any_done = sweep_done;
        repeat (6) begin tick(); any_done = any_done | sweep_done; end
        check("abort_no_done", 64'(any_done), 64'(0));

        // start outside sweep mode is ignored
        sweep_start = 1; tick(); sweep_start = 0;
        check("start_ignored", 64'(sweep_busy), 64'(0));

        // reset mid-sweep
        mode = 1; freq_word = 32'h0100_0000; sweep_len = 8;
        sweep_start = 1; tick(); sweep_start = 0;
        repeat (4) tick();
        check("pre_rst_busy", 64'(sweep_busy), 64'(1));
        #2 rst = 1;
        #1;
        check("mid_rst_sample_out", 64'(sample_out), 64'(0));
        check("mid_rst_valid", 64'(sample_valid), 64'(0));
        check("mid_rst_busy", 64'(sweep_busy), 64'(0));
        check("mid_rst_freq", 64'(dut.freq_cur), 64'(0));
        tick();
        rst = 0;
        repeat (6) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
